rdsel_byte: RTL and testbench



---
 rtl/rdsel_byte.sv | 67 ++++++
 tb/tb_rdsel_byte.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/rdsel_byte.sv
// rdsel_byte: load-path byte read-select.
// Picks one byte lane of a 32-bit read word and zero- or sign-extends it.
// The extended byte is available combinationally on out and as a
// registered copy on out_q (qualified by in_valid) for pipelined writeback.
module rdsel_byte (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        is_signed,
    input  logic [1:0]  sel,
    input  logic [31:0] in,
    output logic [31:0] out,
    output logic [31:0] out_q,
    output logic        out_valid
);

    logic [7:0]  byte_sel;
    logic        ext_bit;
    logic [31:0] out_d;
    logic        valid_d;
    logic        valid_q;

    // Lane mux: little-endian, lane 0 is in[7:0].
    always_comb begin
        // NOTE: assign a default before the case so every path drives
        // byte_sel; a combinational block with an undriven path infers a latch.
        byte_sel = in[7:0];
        case (sel)
            2'd0:    byte_sel = in[7:0];
            2'd1:    byte_sel = in[15:8];
            2'd2:    byte_sel = in[23:16];
            2'd3:    byte_sel = in[31:24];
            default: byte_sel = in[7:0];
        endcase
    end

    // Extension: replicate the byte MSB only for signed loads.
    always_comb begin
        ext_bit = is_signed & byte_sel[7];
        out     = {{24{ext_bit}}, byte_sel};
    end

    // Next-state for the registered copy: capture on in_valid, else hold.
    always_comb begin
        out_d   = out_q;
        valid_d = in_valid;
        if (in_valid) begin
            out_d = out;
        end
    end

    // Writeback register; async reset clears data and valid immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            out_q   <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign out_valid = valid_q;

endmodule

// File: tb/tb_rdsel_byte.sv
// Self-checking bench for rdsel_byte: directed lane/extension vectors,
// registered-stage behaviour, full byte sweep and mid-stream reset.
module tb_rdsel_byte;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        is_signed;
    logic [1:0]  sel;
    logic [31:0] din;
    logic [31:0] dout;
    logic [31:0] dout_q;
    logic        dout_valid;

    int n_cmp = 0;
    int n_err = 0;

    rdsel_byte dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .is_signed (is_signed),
        .sel       (sel),
        .in        (din),
        .out       (dout),
        .out_q     (dout_q),
        .out_valid (dout_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: byte value below 0x80 or unsigned -> zero-extend, else ones above.
    function automatic logic [31:0] ref_ext(input logic [7:0] b, input logic s);
        if (s && (b >= 8'h80)) return 32'hFFFFFF00 | {24'h0, b};
        else                   return {24'h0, b};
    endfunction

    typedef struct {
        logic [1:0]  sel;
        logic        sgn;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[8] = '{
        '{2'd0, 1'b0, 32'h0000000C},
        '{2'd0, 1'b1, 32'h0000000C},
        '{2'd1, 1'b0, 32'h000000FD},
        '{2'd1, 1'b1, 32'hFFFFFFFD},
        '{2'd2, 1'b0, 32'h0000008E},
        '{2'd2, 1'b1, 32'hFFFFFF8E},
        '{2'd3, 1'b0, 32'h00000078},
        '{2'd3, 1'b1, 32'h00000078}
    };

    logic [31:0] exp_q;
    logic        exp_v;
    logic [31:0] exp_out;
    logic [31:0] word;
    int          iter;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        is_signed = 1'b0;
        sel       = 2'd0;
        din       = 32'h788EFD0C;
        #1;
        check("reset out_q", dout_q, 32'h0);
        check("reset out_valid", {31'h0, dout_valid}, 32'h0);

        // Directed vectors, applied while reset is held: out must not care.
        for (int i = 0; i < 8; i++) begin
            sel       = vecs[i].sel;
            is_signed = vecs[i].sgn;
            #1;
            check($sformatf("dir sel=%0d s=%0d", vecs[i].sel, vecs[i].sgn), dout, vecs[i].exp);
        end

        // Release and first capture.
        @(negedge clk);
        rst_n     = 1'b1;
        in_valid  = 1'b1;
        sel       = 2'd2;
        is_signed = 1'b1;
        @(posedge clk); #1;
        check("first capture out_q", dout_q, 32'hFFFFFF8E);
        check("first capture out_valid", {31'h0, dout_valid}, 32'h1);

        // Hold with in_valid low while inputs change.
        @(negedge clk);
        in_valid = 1'b0;
        sel      = 2'd0;
        @(posedge clk); #1;
        check("hold out_q", dout_q, 32'hFFFFFF8E);
        check("hold out_valid", {31'h0, dout_valid}, 32'h0);
        check("hold out comb", dout, 32'h0000000C);

        // Sweep: every byte value in every lane, both extensions.
        exp_q = 32'hFFFFFF8E;
        exp_v = 1'b0;
        iter  = 0;
        for (int v = 0; v < 256; v++) begin
            for (int l = 0; l < 4; l++) begin
                for (int s = 0; s < 2; s++) begin
                    @(negedge clk);
                    word = $urandom;
                    word[8*l +: 8] = v[7:0];
                    din       = word;
                    sel       = l[1:0];
                    is_signed = s[0];
                    in_valid  = (iter == 700) ? 1'b1 : 1'($urandom_range(0, 1));
                    exp_out   = ref_ext(v[7:0], s[0]);
                    #1;
                    check($sformatf("sweep out v=%02h l=%0d s=%0d", v, l, s), dout, exp_out);
                    @(posedge clk); #1;
                    exp_v = in_valid;
                    if (in_valid) exp_q = exp_out;
                    check($sformatf("sweep out_q v=%02h l=%0d s=%0d", v, l, s), dout_q, exp_q);
                    check("sweep out_valid", {31'h0, dout_valid}, {31'h0, exp_v});

                    if (iter == 700) begin
                        // Async clear mid-stream, held across an edge with a
                        // pending capture, which must be discarded.
                        #2;
                        rst_n = 1'b0;
                        #1;
                        check("midrst out_q", dout_q, 32'h0);
                        check("midrst out_valid", {31'h0, dout_valid}, 32'h0);
                        check("midrst out comb", dout, exp_out);
                        @(posedge clk); #1;
                        check("midrst pending out_q", dout_q, 32'h0);
                        check("midrst pending out_valid", {31'h0, dout_valid}, 32'h0);
                        @(negedge clk);
                        rst_n    = 1'b1;
                        in_valid = 1'b0;
                        exp_q    = 32'h0;
                        exp_v    = 1'b0;
                    end
                    iter++;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
